handshake_responder: RTL and testbench

//   Clocked consumer for the four-phase req/ack channels that a locker_param

---
 rtl/handshake_responder.sv | 145 ++++++++++++++
 tb/tb_handshake_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_responder.sv
// Clocked four-phase req/ack responder: synchronises async requests, serves one
// channel at a time and reports each accepted event as a one-cycle pulse.
module handshake_responder #(
  parameter int unsigned size        = 2,
  parameter int unsigned sync_stages = 2,
  parameter int unsigned ack_delay   = 2,
  parameter int unsigned cnt_width   = 16,
  localparam int unsigned chan_w     = (size > 1) ? $clog2(size) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [size-1:0]      req_in,
  output logic [size-1:0]      ack_out,
  output logic                 ev_valid,
  output logic [chan_w-1:0]    ev_chan,
  output logic [cnt_width-1:0] ev_count,
  output logic                 busy,
  output logic                 err_multi,
  output logic                 err_drop
);

  localparam int unsigned stages = (sync_stages < 2) ? 2 : sync_stages;
  localparam int unsigned dly_w  = (ack_delay > 0) ? $clog2(ack_delay + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [chan_w-1:0]      chan, chan_nxt;
  logic [dly_w-1:0]       cnt, cnt_nxt;
  logic                   set_multi, set_drop;

  logic [stages*size-1:0] sync_q;
  logic [size-1:0]        req_s;
  logic                   req_multi;

  logic [size-1:0]        ack_nxt;
  logic                   ev_valid_nxt;
  logic [chan_w-1:0]      ev_chan_nxt;
  logic [cnt_width-1:0]   ev_count_nxt;
  logic                   busy_nxt;
  logic                   err_multi_nxt;
  logic                   err_drop_nxt;
  logic                   entering_ack;

  function automatic logic [chan_w-1:0] lowest_bit(input logic [size-1:0] v);
    lowest_bit = '0;
    for (int i = int'(size) - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit = chan_w'(i);
    end
  endfunction

  // Synchroniser chain; the oldest slice is the request view the FSM uses.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[(stages-1)*size-1:0], req_in};
  end

  assign req_s     = sync_q[stages*size-1 -: size];
  assign req_multi = |(req_s & (req_s - size'(1)));

  // State register together with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      chan      <= '0;
      cnt       <= '0;
      ack_out   <= '0;
      ev_valid  <= 1'b0;
      ev_chan   <= '0;
      ev_count  <= '0;
      busy      <= 1'b0;
      err_multi <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      state     <= state_nxt;
      chan      <= chan_nxt;
      cnt       <= cnt_nxt;
      ack_out   <= ack_nxt;
      ev_valid  <= ev_valid_nxt;
      ev_chan   <= ev_chan_nxt;
      ev_count  <= ev_count_nxt;
      busy      <= busy_nxt;
      err_multi <= err_multi_nxt;
      err_drop  <= err_drop_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    chan_nxt  = chan;
    cnt_nxt   = cnt;
    set_multi = 1'b0;
    set_drop  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req_s) begin
          chan_nxt  = lowest_bit(req_s);
          cnt_nxt   = dly_w'(ack_delay);
          set_multi = req_multi;
          state_nxt = (ack_delay == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req_s[chan]) begin
          set_drop  = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == dly_w'(1)) begin
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - dly_w'(1);
        end
      end
      S_ACK: begin
        if (!req_s[chan]) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values are derived from the upcoming state so they register in step with it.
  always_comb begin
    entering_ack  = (state_nxt == S_ACK) && (state != S_ACK);
    ack_nxt       = '0;
    if (state_nxt == S_ACK) ack_nxt = size'(1) << chan_nxt;
    ev_valid_nxt  = entering_ack;
    ev_chan_nxt   = entering_ack ? chan_nxt : ev_chan;
    ev_count_nxt  = ev_count;
    if (entering_ack && (ev_count != '1)) ev_count_nxt = ev_count + cnt_width'(1);
    busy_nxt      = (state_nxt != S_IDLE);
    err_multi_nxt = err_multi | set_multi;
    err_drop_nxt  = err_drop | set_drop;
  end

endmodule

// File: tb/tb_handshake_responder.sv
// Self-checking bench for handshake_responder: event scoreboard plus per-scenario checks.
module tb_handshake_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_in = 2'b00;
  logic [1:0]  ack_out;
  logic        ev_valid;
  logic [0:0]  ev_chan;
  logic [15:0] ev_count;
  logic        busy, err_multi, err_drop;

  logic        rst_sat = 1'b1;
  logic [1:0]  req_sat = 2'b00;
  logic [1:0]  ack_sat;
  logic        ev_valid_sat;
  logic [0:0]  ev_chan_sat;
  logic [1:0]  ev_count_sat;
  logic        busy_sat, err_multi_sat, err_drop_sat;

  typedef struct packed {
    logic [0:0]  chan;
    logic [15:0] count;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] exp_count = 16'd0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  handshake_responder #(.size(2), .sync_stages(2), .ack_delay(2), .cnt_width(16)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out), .ev_valid(ev_valid),
    .ev_chan(ev_chan), .ev_count(ev_count), .busy(busy), .err_multi(err_multi),
    .err_drop(err_drop)
  );

  handshake_responder #(.size(2), .sync_stages(2), .ack_delay(2), .cnt_width(2)) dut_sat (
    .clk(clk), .rst(rst_sat), .req_in(req_sat), .ack_out(ack_sat), .ev_valid(ev_valid_sat),
    .ev_chan(ev_chan_sat), .ev_count(ev_count_sat), .busy(busy_sat),
    .err_multi(err_multi_sat), .err_drop(err_drop_sat)
  );

  // Scoreboard: every event pulse must match the oldest expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (ev_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ev_unexpected: got chan=%0d count=%0d, required no event", ev_chan, ev_count);
      end else begin
        e = exp_q.pop_front();
        if (ev_chan !== e.chan || ev_count !== e.count) begin
          errors++;
          $display("FAIL ev_scoreboard: got chan=%0d count=%0d, required chan=%0d count=%0d",
                   ev_chan, ev_count, e.chan, e.count);
        end
      end
    end
  end

  task automatic push_event(input int ch);
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    exp_q.push_back('{chan: 1'(ch), count: exp_count});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    req_in = 2'b00;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    exp_count = 16'd0;
    exp_q.delete();
  endtask

  task automatic wait_ack(input bit sat, input logic [1:0] want, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((sat ? ack_sat : ack_out) === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input bit sat, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((sat ? busy_sat : busy) === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake(input int ch);
    bit ok;
    logic [1:0] oh;
    oh = 2'b01 << ch;
    push_event(ch);
    req_in = oh;
    wait_ack(1'b0, oh, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hs_ack_rise ch%0d: ack=%b, required %b", ch, ack_out, oh); end
    req_in = 2'b00;
    wait_ack(1'b0, 2'b00, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hs_ack_fall ch%0d: ack=%b, required 00", ch, ack_out); end
    wait_idle(1'b0, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hs_idle ch%0d: busy=%b, required 0", ch, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack_out, ev_valid, ev_chan, ev_count, err_multi, err_drop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b ev_valid=%b ev_chan=%0d ev_count=%0d err_multi=%b err_drop=%b, required all 0",
               ack_out, ev_valid, ev_chan, ev_count, err_multi, err_drop);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
  endtask

  task automatic test_handshake_latency();
    bit ok;
    do_reset();
    push_event(0);
    req_in = 2'b01;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_out !== 2'b00) begin errors++; $display("FAIL lat_rise_early: ack=%b after 4 edges, required 00", ack_out); end
    @(negedge clk);
    checks++;
    if (ack_out !== 2'b01) begin errors++; $display("FAIL lat_rise: ack=%b after 5 edges, required 01", ack_out); end
    checks++;
    if (ev_count !== 16'd1) begin errors++; $display("FAIL lat_count: ev_count=%0d, required 1", ev_count); end
    req_in = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if (ack_out !== 2'b01) begin errors++; $display("FAIL lat_fall_early: ack=%b after 2 edges, required 01", ack_out); end
    @(negedge clk);
    checks++;
    if (ack_out !== 2'b00) begin errors++; $display("FAIL lat_fall: ack=%b after 3 edges, required 00", ack_out); end
    wait_idle(1'b0, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lat_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    handshake(1);
    checks++;
    if (ev_chan !== 1'b1) begin errors++; $display("FAIL b2b_chan1: ev_chan=%0d, required 1", ev_chan); end
    handshake(0);
    checks++;
    if (ev_chan !== 1'b0) begin errors++; $display("FAIL b2b_chan0: ev_chan=%0d, required 0", ev_chan); end
    checks++;
    if (ev_count !== 16'd2) begin errors++; $display("FAIL b2b_count: ev_count=%0d, required 2", ev_count); end
    checks++;
    if ({err_multi, err_drop} !== 2'b00) begin
      errors++; $display("FAIL b2b_errors: err_multi=%b err_drop=%b, required 0 0", err_multi, err_drop);
    end
  endtask

  task automatic test_multi();
    bit ok;
    bit bad;
    do_reset();
    push_event(0);
    push_event(1);
    req_in = 2'b11;
    wait_ack(1'b0, 2'b01, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_ack0: ack=%b, required 01", ack_out); end
    checks++;
    if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_err: err_multi=%b, required 1", err_multi); end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_out !== 2'b01) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL multi_hold: ack=%b while both req high, required 01", ack_out); end
    req_in = 2'b10;
    wait_ack(1'b0, 2'b10, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_ack1: ack=%b, required 10", ack_out); end
    checks++;
    if (ev_count !== 16'd2) begin errors++; $display("FAIL multi_count: ev_count=%0d, required 2", ev_count); end
    req_in = 2'b00;
    wait_ack(1'b0, 2'b00, 20, ok);
    wait_idle(1'b0, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_drop();
    bit bad;
    do_reset();
    req_in = 2'b01;
    @(negedge clk);
    req_in = 2'b00;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack_out !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL drop_ack: ack went high (now %b), required 00", ack_out); end
    checks++;
    if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err: err_drop=%b, required 1", err_drop); end
    checks++;
    if (ev_count !== 16'd0) begin errors++; $display("FAIL drop_count: ev_count=%0d, required 0", ev_count); end
    checks++;
    if ({busy, err_multi} !== 2'b00) begin
      errors++; $display("FAIL drop_state: busy=%b err_multi=%b, required 0 0", busy, err_multi);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push_event(0);
    req_in = 2'b01;
    wait_ack(1'b0, 2'b01, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_ack: ack=%b, required 01", ack_out); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_out !== 2'b00) begin errors++; $display("FAIL rmid_drop: ack=%b on reset edge, required 00", ack_out); end
    checks++;
    if (ev_count !== 16'd0) begin errors++; $display("FAIL rmid_cnt0: ev_count=%0d, required 0", ev_count); end
    rst       = 1'b0;
    exp_count = 16'd0;
    push_event(0);
    wait_ack(1'b0, 2'b01, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_reserve: ack=%b, required 01", ack_out); end
    checks++;
    if (ev_count !== 16'd1) begin errors++; $display("FAIL rmid_count: ev_count=%0d, required 1", ev_count); end
    req_in = 2'b00;
    wait_ack(1'b0, 2'b00, 20, ok);
    wait_idle(1'b0, 20, ok);
  endtask

  task automatic test_saturation();
    bit ok;
    logic [1:0] want;
    rst_sat = 1'b1;
    repeat (2) @(negedge clk);
    rst_sat = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      req_sat = 2'b01;
      wait_ack(1'b1, 2'b01, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sat_ack ev%0d: ack=%b, required 01", n, ack_sat); end
      want = (n > 3) ? 2'd3 : 2'(n);
      checks++;
      if (ev_count_sat !== want) begin
        errors++; $display("FAIL sat_count ev%0d: ev_count=%0d, required %0d", n, ev_count_sat, want);
      end
      req_sat = 2'b00;
      wait_ack(1'b1, 2'b00, 20, ok);
      wait_idle(1'b1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sat_idle ev%0d: busy=%b, required 0", n, busy_sat); end
    end
    checks++;
    if (ev_count_sat !== 2'd3) begin errors++; $display("FAIL sat_final: ev_count=%0d, required 3", ev_count_sat); end
  endtask

  initial begin
    test_reset();
    test_handshake_latency();
    test_back_to_back();
    test_multi();
    test_drop();
    test_reset_mid();
    test_saturation();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL ev_missing: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
